// File: rtl/simple_processor_pkg.sv
// Shared ISA definitions for simple_processor: opcodes, instruction field positions
// and the built-in running-sum program.
package simple_processor_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_IN   = 4'h2,
        OP_OUT  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_SHL  = 4'h9,
        OP_SHR  = 4'hA,
        OP_JMP  = 4'hB,
        OP_JZ   = 4'hC,
        OP_ADDI = 4'hD,
        OP_HALT = 4'hE,
        OP_RSVD = 4'hF
    } opcode_e;

    localparam int DEFAULT_DEPTH = 16;

    // Listed from address 15 down to address 0.
    localparam logic [DEFAULT_DEPTH-1:0][INSTR_W-1:0] DEFAULT_PROG = {
        {11{16'h0000}},
        16'hB001,       // 4: JMP 1
        16'h3100,       // 3: OUT R1
        16'h4400,       // 2: ADD R1,R0
        16'h2000,       // 1: IN  R0
        16'h1400        // 0: LDI R1,0
    };

    function automatic logic writes_rd(input opcode_e op);
        return op inside {OP_LDI, OP_IN, OP_ADD, OP_SUB, OP_AND, OP_OR,
                          OP_XOR, OP_SHL, OP_SHR, OP_ADDI};
    endfunction

endpackage

// File: rtl/simple_processor_alu.sv
// Combinational result path for every register-writing opcode, plus its zero test.
import simple_processor_pkg::*;

module simple_processor_alu #(
    parameter int DATA_W = 16
) (
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [7:0]        imm8,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (op)
            OP_LDI:  result = DATA_W'(imm8);
            OP_IN:   result = b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << 1;
            OP_SHR:  result = a >> 1;
            OP_ADDI: result = a + DATA_W'(imm8);
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/simple_processor.sv
// Single-cycle register machine: fetch from ROM at pc, execute one instruction per
// rising edge, IN reads data_in, OUT updates the data_out register.
import simple_processor_pkg::*;

module simple_processor #(
    parameter int    DATA_W     = 16,
    parameter int    PROG_DEPTH = 16,
    parameter string INIT_FILE  = "",
    parameter logic [PROG_DEPTH-1:0][INSTR_W-1:0] PROG_IMAGE =
        (PROG_DEPTH*INSTR_W)'(DEFAULT_PROG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int PC_W = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
    localparam bit PC_FULL = (PROG_DEPTH == (1 << PC_W));
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_DEPTH - 1);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic              z_q, z_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic               pc_valid;
    logic [INSTR_W-1:0] instr;

    // Addresses past the end of a non-power-of-two ROM fetch as NOP.
    assign pc_valid = PC_FULL || (int'(pc_q) < PROG_DEPTH);

    assign instr = pc_valid ? PROG_IMAGE[pc_q] : '0;

    opcode_e           op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [7:0]        imm8;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   jmp_tgt;

    assign op      = opcode_e'(instr[OP_MSB:OP_LSB]);
    assign rd      = instr[RD_MSB:RD_LSB];
    assign rs      = instr[RS_MSB:RS_LSB];
    assign imm8    = instr[IMM_MSB:IMM_LSB];
    assign alu_b   = (op == OP_IN) ? data_in : regs_q[rs];
    assign pc_inc  = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
    assign jmp_tgt = PC_W'(imm8);

    simple_processor_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op),
        .a      (regs_q[rd]),
        .b      (alu_b),
        .imm8   (imm8),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Once halted every piece of architectural state holds until reset.
    always_comb begin
        pc_d       = pc_q;
        regs_d     = regs_q;
        z_d        = z_q;
        halted_d   = halted_q;
        data_out_d = data_out_q;
        if (!halted_q) begin
            pc_d = pc_inc;
            case (op)
                OP_OUT:  data_out_d = regs_q[rs];
                OP_JMP:  pc_d = jmp_tgt;
                OP_JZ:   if (z_q) pc_d = jmp_tgt;
                OP_HALT: begin
                    halted_d = 1'b1;
                    pc_d     = pc_q;
                end
                default: ;
            endcase
            if (writes_rd(op)) begin
                regs_d[rd] = alu_result;
                z_d        = alu_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            z_q        <= 1'b0;
            halted_q   <= 1'b0;
            data_out_q <= '0;
        end else begin
            pc_q       <= pc_d;
            regs_q     <= regs_d;
            z_q        <= z_d;
            halted_q   <= halted_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_simple_processor.sv
// Bench for simple_processor: five cores with different ROM images share clk/rst/data_in;
// fixed vectors, hand-written corner sequences and a random run against an ISA interpreter.
module tb_simple_processor;

    localparam int NP = 5;

    // Images listed from address 15 down to address 0.
    localparam logic [15:0][15:0] P_DEF = {{11{16'h0000}}, 16'hB001, 16'h3100,
                                           16'h4400, 16'h2000, 16'h1400};
    localparam logic [15:0][15:0] P4 = {{6{16'h0000}}, 16'hE000, 16'h3200, 16'h185A,
                                        16'h3100, 16'hC007, 16'h5000, 16'h3000,
                                        16'h4100, 16'h1401, 16'h10FF};
    localparam logic [15:0][15:0] P5 = {{3{16'h0000}}, 16'h3100, 16'hE000, 16'h3000,
                                        16'hD034, {8{16'h9000}}, 16'h1012};
    localparam logic [15:0][15:0] P6 = {16'h3000, {15{16'h0000}}};
    localparam logic [15:0][15:0] PMIX = {16'h3000, 16'hC000, 16'h3100, 16'h6100,
                                          16'hD080, 16'hA000, 16'h7100, 16'h3000,
                                          16'h5100, 16'h9000, 16'h3100, 16'h8400,
                                          16'h3000, 16'h4100, 16'h2400, 16'h2000};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] dout [NP];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    simple_processor u_def (.clk(clk), .rst(rst), .data_in(data_in), .data_out(dout[0]));
    simple_processor #(.PROG_IMAGE(P4))   u_p4  (.clk(clk), .rst(rst), .data_in(data_in), .data_out(dout[1]));
    simple_processor #(.PROG_IMAGE(P5))   u_p5  (.clk(clk), .rst(rst), .data_in(data_in), .data_out(dout[2]));
    simple_processor #(.PROG_IMAGE(P6))   u_p6  (.clk(clk), .rst(rst), .data_in(data_in), .data_out(dout[3]));
    simple_processor #(.PROG_IMAGE(PMIX)) u_mix (.clk(clk), .rst(rst), .data_in(data_in), .data_out(dout[4]));

    // ---------------- ISA-level reference interpreter ----------------
    typedef struct packed {
        logic [3:0]       pc;
        logic [3:0][15:0] r;
        logic             z;
        logic             h;
        logic [15:0]      out;
    } mstate_t;

    logic [15:0] progs [NP][16];
    mstate_t     ms [NP];

    function automatic mstate_t next_state(input mstate_t s, input logic [15:0] ins,
                                           input logic [15:0] din);
        mstate_t     n;
        logic [3:0]  op;
        logic [1:0]  rd;
        logic [1:0]  rs;
        logic [15:0] imm;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        bit          wr;
        n   = s;
        op  = ins[15:12];
        rd  = ins[11:10];
        rs  = ins[9:8];
        imm = {8'h00, ins[7:0]};
        a   = s.r[rd];
        b   = s.r[rs];
        res = 16'h0000;
        wr  = 1'b1;
        if (s.h) return s;
        n.pc = s.pc + 4'd1;
        case (op)
            4'h1: res = imm;
            4'h2: res = din;
            4'h4: res = a + b;
            4'h5: res = a - b;
            4'h6: res = a & b;
            4'h7: res = a | b;
            4'h8: res = a ^ b;
            4'h9: res = {a[14:0], 1'b0};
            4'hA: res = {1'b0, a[15:1]};
            4'hD: res = a + imm;
            default: wr = 1'b0;
        endcase
        case (op)
            4'h3: n.out = b;
            4'hB: n.pc = imm[3:0];
            4'hC: if (s.z) n.pc = imm[3:0];
            4'hE: begin n.h = 1'b1; n.pc = s.pc; end
            default: ;
        endcase
        if (wr) begin
            n.r[rd] = res;
            n.z     = (res == 16'h0000);
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < NP; k++) begin
            if (!rst) ms[k] <= '0;
            else      ms[k] <= next_state(ms[k], progs[k][ms[k].pc], data_in);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        string       name;
        int          prog;
        logic [15:0] din;
        int          edges;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            progs[0][i] = P_DEF[i];
            progs[1][i] = P4[i];
            progs[2][i] = P5[i];
            progs[3][i] = P6[i];
            progs[4][i] = PMIX[i];
        end

        vecs[0]  = '{"def_e3",     0, 16'h0003,  3, 16'h0000};
        vecs[1]  = '{"def_e4",     0, 16'h0003,  4, 16'h0003};
        vecs[2]  = '{"def_e8",     0, 16'h0003,  8, 16'h0006};
        vecs[3]  = '{"def_e12",    0, 16'h0003, 12, 16'h0009};
        vecs[4]  = '{"wrap_e4",    0, 16'h8000,  4, 16'h8000};
        vecs[5]  = '{"wrap_e8",    0, 16'h8000,  8, 16'h0000};
        vecs[6]  = '{"wrap_e12",   0, 16'h8000, 12, 16'h8000};
        vecs[7]  = '{"def_ffff",   0, 16'hFFFF,  8, 16'hFFFE};
        vecs[8]  = '{"p4_out",     1, 16'h0000,  4, 16'h0100};
        vecs[9]  = '{"p4_jz_skip", 1, 16'h0000,  7, 16'h0100};
        vecs[10] = '{"p4_taken",   1, 16'h0000,  8, 16'h005A};
        vecs[11] = '{"p4_halt",    1, 16'h0000, 20, 16'h005A};
        vecs[12] = '{"p5_out",     2, 16'h0000, 11, 16'h1234};
        vecs[13] = '{"p6_wrap",    3, 16'h0000, 35, 16'h0000};

        // Reset state: every core's output register is clear while rst is low.
        @(posedge clk);
        #1;
        for (int k = 0; k < NP; k++) check($sformatf("reset_state_u%0d", k), dout[k], 16'h0000);

        for (int v = 0; v < 14; v++) begin
            apply_reset();
            data_in = vecs[v].din;
            repeat (vecs[v].edges) @(posedge clk);
            #1;
            check(vecs[v].name, dout[vecs[v].prog], vecs[v].exp);
        end

        // Async reset mid-run, then restart from pc 0 with a cleared sum.
        apply_reset();
        data_in = 16'h0005;
        repeat (6) @(posedge clk);
        #1;
        check("midrun_pre", dout[0], 16'h0005);
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < NP; k++) check($sformatf("async_clear_u%0d", k), dout[k], 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        data_in = 16'h0002;
        repeat (3) @(posedge clk);
        #1;
        check("restart_e3", dout[0], 16'h0000);
        @(posedge clk);
        #1;
        check("restart_e4", dout[0], 16'h0002);

        // HALT freezes data_out while data_in keeps moving.
        apply_reset();
        data_in = 16'h0000;
        repeat (11) @(posedge clk);
        #1;
        check("halt_out", dout[2], 16'h1234);
        for (int c = 0; c < 50; c++) begin
            data_in = c[0] ? 16'hFFFF : 16'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("halt_hold_c%0d", c), dout[2], 16'h1234);
        end

        // NOP ROM with OUT R0 at the last address: pc wraps, output stays clean zero.
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            data_in = 16'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("nop_wrap_c%0d", c), dout[3], 16'h0000);
        end

        // Random data_in with occasional mid-cycle resets, all cores vs the interpreter.
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0: data_in = 16'($urandom_range(0, 3));
                1: data_in = $urandom_range(0, 1) ? 16'hFFFF : 16'h8000;
                default: data_in = 16'($urandom);
            endcase
            @(posedge clk);
            #1;
            for (int k = 0; k < NP; k++)
                check($sformatf("rand_c%0d_u%0d", c, k), dout[k], ms[k].out);
            if ($urandom_range(0, 63) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                for (int k = 0; k < NP; k++)
                    check($sformatf("rand_rst_c%0d_u%0d", c, k), dout[k], 16'h0000);
                @(negedge clk);
                rst = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
